gfp8_result_packer: RTL

Downstream stage of the GFP8 BCV controller. It consumes each (mantissa, exponent) dot-product result and converts it to IEEE FP16. It packs 16 FP16 values per 256-bit line and buffers the lines in a small FIFO. Lines are presented to the result-BRAM writer over a valid/ready handshake, and the tile boundary is marked with a last flag.

---
 rtl/gfp8_pkg.sv | 24 ++
 rtl/gfp8_to_fp16.sv | 111 +++++++++++
 rtl/gfp8_result_packer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/gfp8_pkg.sv
// Shared definitions for the GFP8 result packer.
//   FP16 format limits, packer state encoding and the output line record.
package gfp8_pkg;

  localparam int          FP16_BIAS  = 15;
  localparam logic [15:0] FP16_MAX   = 16'h7BFF;
  localparam int          FP16_EMIN  = -14;
  localparam int          FP16_EMAX  = 15;

  localparam int LINE_LANES = 16;
  localparam int LINE_W     = 16 * LINE_LANES;

  typedef enum logic {
    PACK  = 1'b0,
    FLUSH = 1'b1
  } pack_state_e;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic [4:0]        count;
    logic              last;
  } line_t;

endpackage

// File: rtl/gfp8_to_fp16.sv
// Two-stage (mantissa, exponent) -> IEEE FP16 converter.
//   i_mantissa/i_exponent : signed value mantissa * 2^exponent
//   i_valid               : value strobe
//   i_done                : end-of-tile sideband, delayed alongside the value
//   o_fp16/o_valid/o_done : result two cycles after the strobe
//   o_busy                : a value is in flight in either stage
module gfp8_to_fp16
  import gfp8_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_mantissa,
  input  logic [7:0]  i_exponent,
  input  logic        i_valid,
  input  logic        i_done,
  output logic [15:0] o_fp16,
  output logic        o_valid,
  output logic        o_done,
  output logic        o_busy
);

  logic        s1_sign_q;
  logic [32:0] s1_mag_q;
  logic [32:0] s1_mag_d;
  logic [7:0]  s1_exp_q;
  logic        s1_valid_q;
  logic        s1_done_q;

  logic [15:0] s2_fp16_q;
  logic [15:0] s2_fp16_d;
  logic        s2_valid_q;
  logic        s2_done_q;

  // 33-bit magnitude so that -2^31 negates without overflow.
  always_comb begin
    s1_mag_d = {i_mantissa[31], i_mantissa};
    if (i_mantissa[31]) s1_mag_d = ~s1_mag_d + 33'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s1_exp_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_done_q  <= 1'b0;
    end else begin
      s1_sign_q  <= i_mantissa[31];
      s1_mag_q   <= s1_mag_d;
      s1_exp_q   <= i_exponent;
      s1_valid_q <= i_valid;
      s1_done_q  <= i_done;
    end
  end

  logic [5:0]        lead;
  logic [5:0]        shamt;
  logic [32:0]       norm;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [10:0]       frac_sum;
  logic signed [9:0] exp_e;
  logic [9:0]        exp_biased;

  always_comb begin
    lead = '0;
    for (int unsigned i = 0; i < 33; i++) begin
      if (s1_mag_q[i]) lead = 6'(i);
    end
    // Left-justify so the leading one sits at bit 32; fraction, guard and
    // sticky then come from fixed bit positions.
    shamt      = 6'd32 - lead;
    norm       = s1_mag_q << shamt;
    guard      = norm[21];
    sticky     = |norm[20:0];
    round_up   = guard & (sticky | norm[22]);
    frac_sum   = {1'b0, norm[31:22]} + {10'b0, round_up};
    exp_e      = $signed({4'b0000, lead})
               + $signed({{2{s1_exp_q[7]}}, s1_exp_q})
               + $signed({9'b0, frac_sum[10]});
    exp_biased = exp_e + 10'(FP16_BIAS);

    s2_fp16_d = {s1_sign_q, exp_biased[4:0], frac_sum[9:0]};
    if (!norm[32]) begin
      s2_fp16_d = '0;
    end else if (exp_e > FP16_EMAX) begin
      s2_fp16_d = {s1_sign_q, FP16_MAX[14:0]};
    end else if (exp_e < FP16_EMIN) begin
      s2_fp16_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s2_fp16_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_done_q  <= 1'b0;
    end else begin
      s2_fp16_q  <= s2_fp16_d;
      s2_valid_q <= s1_valid_q;
      s2_done_q  <= s1_done_q;
    end
  end

  assign o_fp16  = s2_fp16_q;
  assign o_valid = s2_valid_q;
  assign o_done  = s2_done_q;
  assign o_busy  = s1_valid_q | s2_valid_q;

endmodule

// File: rtl/gfp8_result_packer.sv
// Converts dot-product results to FP16, packs LANES values per line and
// buffers lines in a small FIFO for the result-BRAM writer.
//   i_result_*   : result strobe (no backpressure), i_tile_done end-of-tile
//   o_line_*     : FIFO head (data, lane count, tile-last, valid)
//   i_line_ready : consumer pops the head when valid && ready
//   o_overflow   : sticky, a line was dropped on a full FIFO
//   o_busy       : anything in the pipeline, packer or FIFO
module gfp8_result_packer
  import gfp8_pkg::*;
#(
  parameter int LANES          = LINE_LANES,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [31:0]          i_result_mantissa,
  input  logic [7:0]           i_result_exponent,
  input  logic                 i_result_valid,
  input  logic                 i_tile_done,
  output logic [16*LANES-1:0]  o_line_data,
  output logic [4:0]           o_line_count,
  output logic                 o_line_last,
  output logic                 o_line_valid,
  input  logic                 i_line_ready,
  output logic                 o_overflow,
  output logic                 o_busy
);

  localparam int CW = $clog2(LANES);
  localparam int AW = $clog2(OUT_FIFO_DEPTH);

  logic [15:0] cv_fp16;
  logic        cv_valid;
  logic        cv_done;
  logic        cv_busy;

  gfp8_to_fp16 u_conv (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_mantissa (i_result_mantissa),
    .i_exponent (i_result_exponent),
    .i_valid    (i_result_valid),
    .i_done     (i_tile_done),
    .o_fp16     (cv_fp16),
    .o_valid    (cv_valid),
    .o_done     (cv_done),
    .o_busy     (cv_busy)
  );

  pack_state_e         state_q, state_d;
  logic [16*LANES-1:0] lanes_q, lanes_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                overflow_q, overflow_d;

  logic [16*LANES-1:0] line_v;
  logic                push;
  line_t               push_line;
  logic                drop;

  line_t               mem_q [OUT_FIFO_DEPTH];
  logic [AW:0]         wr_q, rd_q;
  logic                empty, full, pop, wr_en;
  line_t               head;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && i_line_ready;
  // A simultaneous pop frees the slot, so a push onto a full FIFO is kept.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_comb begin
    lanes_d   = lanes_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_line = '0;
    line_v    = lanes_q;
    if (cv_valid) begin
      line_v[{cnt_q, 4'b0000} +: 16] = cv_fp16;
      if (cnt_q == CW'(LANES - 1) || cv_done) begin
        push            = 1'b1;
        push_line.data  = line_v;
        push_line.count = 5'(cnt_q) + 5'd1;
        push_line.last  = cv_done;
        lanes_d         = '0;
        cnt_d           = '0;
      end else begin
        lanes_d = line_v;
        cnt_d   = cnt_q + CW'(1);
      end
    end else if (cv_done) begin
      push            = 1'b1;
      push_line.data  = lanes_q;
      push_line.count = 5'(cnt_q);
      push_line.last  = 1'b1;
      lanes_d         = '0;
      cnt_d           = '0;
    end
  end

  // Every push clears the packer, so the dropped line is already gone when
  // FLUSH is entered; FLUSH only marks the drop cycle and arriving values
  // pack into a fresh line in either state.
  always_comb begin
    overflow_d = overflow_q | drop;
    state_d    = PACK;
    unique case (state_q)
      PACK:    state_d = drop ? FLUSH : PACK;
      FLUSH:   state_d = drop ? FLUSH : PACK;
      default: state_d = PACK;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= PACK;
      lanes_q    <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      lanes_q    <= lanes_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      if (wr_en) wr_q <= wr_q + (AW + 1)'(1);
      if (pop)   rd_q <= rd_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= push_line;
  end

  assign head         = mem_q[rd_q[AW-1:0]];
  assign o_line_valid = !empty;
  assign o_line_data  = empty ? '0 : head.data;
  assign o_line_count = empty ? '0 : head.count;
  assign o_line_last  = empty ? 1'b0 : head.last;
  assign o_overflow   = overflow_q;
  assign o_busy       = cv_busy || (cnt_q != '0) || !empty;

endmodule
